// File: rtl/wb_stage.sv
// Writeback stage: M->W pipeline register, result select, register-file write port,
// architectural HI/LO registers committed from divide results, and a retired-instruction counter.
module wb_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MoveHiM,
  input  logic                  MoveLoM,
  input  logic [WIDTH-1:0]      RD,
  input  logic [WIDTH-1:0]      ALUOutM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic                  HasDivM,
  input  logic [WIDTH-1:0]      DivHiM,
  input  logic [WIDTH-1:0]      DivLoM,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [WIDTH-1:0]      ResultW,
  output logic [WIDTH-1:0]      HiW,
  output logic [WIDTH-1:0]      LoW,
  output logic [CNT_W-1:0]      RetiredW
);

  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_memtoreg;
  logic                  r_movehi;
  logic                  r_movelo;
  logic                  r_hasdiv;
  logic [WIDTH-1:0]      r_rd;
  logic [WIDTH-1:0]      r_aluout;
  logic [REG_ADDR_W-1:0] r_writereg;
  logic [WIDTH-1:0]      r_divhi;
  logic [WIDTH-1:0]      r_divlo;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic [CNT_W-1:0]      r_retired;

  logic                  w_commit;
  logic [WIDTH-1:0]      w_result;

  // A stalled or flushed instruction never commits, even if it is valid.
  assign w_commit = r_valid & ~StallW & ~FlushW;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_movehi   <= 1'b0;
      r_movelo   <= 1'b0;
      r_hasdiv   <= 1'b0;
      r_rd       <= '0;
      r_aluout   <= '0;
      r_writereg <= '0;
      r_divhi    <= '0;
      r_divlo    <= '0;
    end else if (FlushW) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_movehi   <= 1'b0;
      r_movelo   <= 1'b0;
      r_hasdiv   <= 1'b0;
      r_rd       <= '0;
      r_aluout   <= '0;
      r_writereg <= '0;
      r_divhi    <= '0;
      r_divlo    <= '0;
    end else if (!StallW) begin
      r_valid    <= ValidM;
      r_regwrite <= RegWriteM;
      r_memtoreg <= MemtoRegM;
      r_movehi   <= MoveHiM;
      r_movelo   <= MoveLoM;
      r_hasdiv   <= HasDivM;
      r_rd       <= RD;
      r_aluout   <= ALUOutM;
      r_writereg <= WriteRegM;
      r_divhi    <= DivHiM;
      r_divlo    <= DivLoM;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + CNT_W'(1);
      if (r_hasdiv) begin
        r_hi <= r_divhi;
        r_lo <= r_divlo;
      end
    end
  end

  // mfhi/mflo read the committed HI/LO; a divide one slot ahead has already committed.
  always_comb begin
    w_result = r_aluout;
    if (r_movehi) begin
      w_result = r_hi;
    end else if (r_movelo) begin
      w_result = r_lo;
    end else if (r_memtoreg) begin
      w_result = r_rd;
    end
  end

  assign RegWriteW = r_valid & r_regwrite & ~StallW & (r_writereg != '0);
  assign WriteRegW = r_writereg;
  assign ResultW   = w_result;
  assign HiW       = r_hi;
  assign LoW       = r_lo;
  assign RetiredW  = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected W outputs are queued as stimulus is driven
// and popped after the following clock edge.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallW, FlushW, ValidM, RegWriteM, MemtoRegM, MoveHiM, MoveLoM, HasDivM;
  logic [31:0] RD, ALUOutM, DivHiM, DivLoM;
  logic [4:0]  WriteRegM;

  logic        RegWriteW, RegWriteW4;
  logic [4:0]  WriteRegW, WriteRegW4;
  logic [31:0] ResultW, HiW, LoW, ResultW4, HiW4, LoW4;
  logic [31:0] RetiredW;
  logic [3:0]  RetiredW4;

  logic [133:0] obs;
  assign obs = {RegWriteW, WriteRegW, ResultW, HiW, LoW, RetiredW};

  typedef struct {
    string        name;
    logic [133:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  wb_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MoveHiM(MoveHiM), .MoveLoM(MoveLoM),
    .RD(RD), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .HasDivM(HasDivM),
    .DivHiM(DivHiM), .DivLoM(DivLoM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .HiW(HiW), .LoW(LoW), .RetiredW(RetiredW)
  );

  wb_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MoveHiM(MoveHiM), .MoveLoM(MoveLoM),
    .RD(RD), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .HasDivM(HasDivM),
    .DivHiM(DivHiM), .DivLoM(DivLoM), .RegWriteW(RegWriteW4), .WriteRegW(WriteRegW4),
    .ResultW(ResultW4), .HiW(HiW4), .LoW(LoW4), .RetiredW(RetiredW4)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic v, input logic rw, input logic mem, input logic mh,
                     input logic ml, input logic hd, input logic [4:0] wr,
                     input logic [31:0] rd_v, input logic [31:0] alu,
                     input logic [31:0] dh, input logic [31:0] dl);
    ValidM = v; RegWriteM = rw; MemtoRegM = mem; MoveHiM = ml ? 1'b0 : mh;
    MoveHiM = mh; MoveLoM = ml; HasDivM = hd; WriteRegM = wr;
    RD = rd_v; ALUOutM = alu; DivHiM = dh; DivLoM = dl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic push(input string n, input logic rw, input logic [4:0] wr,
                      input logic [31:0] res, input logic [31:0] hi,
                      input logic [31:0] lo, input logic [31:0] ret);
    exp_t e;
    e.name = n;
    e.v    = {rw, wr, res, hi, lo, ret};
    q.push_back(e);
  endtask

  task automatic reset_pulse();
    StallW = 0; FlushW = 0; idle();
    RST = 1;
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1;
    for (int i = 0; i < 3; i++) begin
      {StallW, FlushW, ValidM, RegWriteM, MemtoRegM, MoveHiM, MoveLoM, HasDivM} = 8'($urandom);
      RD = $urandom; ALUOutM = $urandom; DivHiM = $urandom; DivLoM = $urandom;
      WriteRegM = 5'($urandom);
      push("reset", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
      e = q.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
    end
    StallW = 0; FlushW = 0; idle();
    RST = 0;
  endtask

  task automatic test_alu();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        drv(1, 1, 0, 0, 0, 0, 5'd5, 32'h0, 32'h1234, 32'h0, 32'h0);
        push("alu_load", 1, 5'd5, 32'h1234, 32'd0, 32'd0, 32'd0);
      end else begin
        idle();
        push("alu_retire", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd1);
      end
      tick();
      e = q.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          drv(1, 1, 1, 0, 0, 0, 5'd3, 32'hFFFFFF80, 32'h10, 32'h0, 32'h0);
          push("load", 1, 5'd3, 32'hFFFFFF80, 32'd0, 32'd0, 32'd1);
        end
        1: begin
          drv(1, 1, 1, 0, 0, 0, 5'd0, 32'h0000ABCD, 32'h10, 32'h0, 32'h0);
          push("load_r0", 0, 5'd0, 32'h0000ABCD, 32'd0, 32'd0, 32'd2);
        end
        default: begin
          idle();
          push("load_done", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd3);
        end
      endcase
      tick();
      e = q.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin // divide: rem 7 -> HI, quot 3 -> LO
          drv(1, 0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h55, 32'd7, 32'd3);
          push("div", 0, 5'd0, 32'h55, 32'd0, 32'd0, 32'd3);
        end
        1: begin
          drv(1, 1, 0, 1, 0, 0, 5'd8, 32'h0, 32'h99, 32'h0, 32'h0);
          push("mfhi", 1, 5'd8, 32'd7, 32'd7, 32'd3, 32'd4);
        end
        2: begin
          drv(1, 1, 0, 0, 1, 0, 5'd9, 32'h0, 32'h99, 32'h0, 32'h0);
          push("mflo", 1, 5'd9, 32'd3, 32'd7, 32'd3, 32'd5);
        end
        3: begin
          idle();
          push("move_done", 0, 5'd0, 32'd0, 32'd7, 32'd3, 32'd6);
        end
        4: begin // both divide and mfhi: result is the old HI
          drv(1, 1, 0, 1, 0, 1, 5'd10, 32'h0, 32'h0, 32'h11, 32'h22);
          push("div_mfhi", 1, 5'd10, 32'd7, 32'd7, 32'd3, 32'd6);
        end
        5: begin
          drv(1, 1, 1, 0, 1, 0, 5'd11, 32'hDEAD, 32'h44, 32'h0, 32'h0);
          push("lo_over_mem", 1, 5'd11, 32'h22, 32'h11, 32'h22, 32'd7);
        end
        default: begin
          idle();
          push("prio_done", 0, 5'd0, 32'd0, 32'h11, 32'h22, 32'd8);
        end
      endcase
      tick();
      e = q.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    reset_pulse();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin
          drv(1, 1, 0, 0, 0, 1, 5'd4, 32'h0, 32'h40, 32'h77, 32'h66);
          push("sf_div", 1, 5'd4, 32'h40, 32'd0, 32'd0, 32'd0);
        end
        1, 2, 3: begin
          StallW = 1;
          drv(1, 1, 0, 0, 0, 0, 5'd6, 32'h0, 32'hBAD, 32'h0, 32'h0);
          push("sf_stall", 0, 5'd4, 32'h40, 32'd0, 32'd0, 32'd0);
        end
        4: begin
          StallW = 1; FlushW = 1;
          push("sf_flush", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
        5: begin
          StallW = 0; FlushW = 0; idle();
          push("sf_after", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
        6: begin
          drv(1, 1, 0, 0, 0, 1, 5'd7, 32'h0, 32'h70, 32'h5, 32'h6);
          push("rs_load", 1, 5'd7, 32'h70, 32'd0, 32'd0, 32'd0);
        end
        7: begin
          StallW = 1;
          push("rs_stall", 0, 5'd7, 32'h70, 32'd0, 32'd0, 32'd0);
        end
        8: begin // reset mid-stall, away from any clock edge
          #2;
          RST = 1;
          push("rs_async", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
        default: begin
          RST = 0;
          push("rs_hold", 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
      endcase
      if (c == 8) #1;
      else tick();
      e = q.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
    end
    StallW = 0; FlushW = 0; idle();
    tick();
  endtask

  task automatic test_wrap();
    int n = 0;
    int k = 0;
    reset_pulse();
    while (n < 17) begin
      if (k % 3 == 2) drv(0, 1, 0, 0, 0, 0, 5'd2, 32'h0, 32'h5, 32'h0, 32'h0);
      else begin
        drv(1, 1, 0, 0, 0, 0, 5'd1, 32'h0, 32'(k), 32'h0, 32'h0);
        n++;
      end
      tick();
      k++;
    end
    idle();
    tick();
    n_checks++;
    if (RetiredW !== 32'd17) $display("FAIL wrap_cnt32: got %0d expected 17", RetiredW);
    else n_pass++;
    n_checks++;
    if ({RegWriteW4, WriteRegW4, ResultW4, HiW4, LoW4, RetiredW4} !== {1'b0, 5'd0, 96'd0, 4'd1})
      $display("FAIL wrap_cnt4: got retired %0d result %h expected retired 1 result 0",
               RetiredW4, ResultW4);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    StallW = 0; FlushW = 0; idle();
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_stall_flush();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
